// File: rtl/scratch_pad_pkg.sv
// Shared types and helpers for the ping/pong scratch pad.
package scratch_pad_pkg;

    // Bank ownership: the writer owns Empty/Filling, the reader owns Full/Draining.
    typedef enum logic [1:0] {
        BankEmpty    = 2'd0,
        BankFilling  = 2'd1,
        BankFull     = 2'd2,
        BankDraining = 2'd3
    } bank_state_e;

    localparam int unsigned LANE_W_DEF = 64;

    // Bit offset of lane `lane` within a line built from `lane_w`-bit lanes.
    function automatic int unsigned lane_slice(input int unsigned lane, input int unsigned lane_w);
        return lane * lane_w;
    endfunction

endpackage

// File: rtl/sp_bank.sv
// One scratch-pad bank: simple dual-port RAM with registered read, no reset on storage.
module sp_bank #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic                     i_re,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output logic [WIDTH-1:0]         o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdata;

    // Write port and registered read port; maps onto block RAM.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/scratch_pad_pingpong.sv
// Double-buffered scratch pad: one bank fills while the other streams out as A/B operands.
// Optional build macro SCRATCH_PAD_REPLAY_EN adds rd_repeat (stream each bank N+1 times).
module scratch_pad_pingpong
    import scratch_pad_pkg::*;
#(
    parameter int unsigned LANE_W  = LANE_W_DEF,
    parameter int unsigned A_LANES = 1,
    parameter int unsigned B_LANES = 64,
    parameter int unsigned DEPTH   = 16
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              wr_valid,
    output logic                              wr_ready,
    input  logic [(A_LANES+B_LANES)*LANE_W-1:0] wr_data,
    input  logic                              wr_last,
`ifdef SCRATCH_PAD_REPLAY_EN
    input  logic [7:0]                        rd_repeat,
`endif
    output logic                              rd_valid,
    input  logic                              rd_ready,
    output logic [A_LANES*LANE_W-1:0]         rd_data_a,
    output logic [B_LANES*LANE_W-1:0]         rd_data_b,
    output logic                              rd_last,
    output logic [1:0]                        bank_full
);

    localparam int unsigned LANES = A_LANES + B_LANES;
    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned CW    = AW + 1;
    localparam int unsigned LW    = LANES * LANE_W;
    localparam int unsigned A_LSB = lane_slice(0, LANE_W);
    localparam int unsigned B_LSB = lane_slice(A_LANES, LANE_W);

    bank_state_e   r_state [2];
    bank_state_e   w_state_d [2];
    logic [CW-1:0] r_fcnt [2];
    logic [CW-1:0] w_fcnt_d [2];
    logic          r_wr_bank, r_rd_bank;
    logic [AW-1:0] r_wptr, r_rptr;
    logic          r_iss_done;
    logic          r_inflight, r_q_last;
    logic [LW-1:0] r_skid_data [2];
    logic          r_skid_last [2];
    logic          r_head;
    logic [1:0]    r_count;
    logic [LW-1:0] w_q [2];

    logic        w_wr_ready, w_wr_fire, w_commit;
    logic        w_rd_valid, w_pop, w_release;
    logic        w_room, w_issue, w_iss_end, w_iss_last, w_slot;
    logic [7:0]  w_pass_cur;
    bank_state_e w_rd_state;
    logic [LW-1:0] w_head_line;

    assign w_rd_state = r_state[r_rd_bank];
    assign w_wr_ready = (r_state[r_wr_bank] == BankEmpty) || (r_state[r_wr_bank] == BankFilling);
    assign w_wr_fire  = wr_valid && w_wr_ready;
    assign w_commit   = w_wr_fire && ((r_wptr == AW'(DEPTH - 1)) || wr_last);
    assign w_rd_valid = (r_count != 2'd0);
    assign w_pop      = w_rd_valid && rd_ready;
    assign w_release  = w_pop && r_skid_last[r_head];

    // Issue only if the skid can absorb it two cycles out; counting this cycle's pop keeps
    // the stream at one line per cycle while the consumer is ready.
    assign w_room     = ({1'b0, r_count} + {2'b00, r_inflight}) <= (3'd1 + {2'b00, w_pop});
    assign w_issue    = ((w_rd_state == BankFull) ||
                         ((w_rd_state == BankDraining) && !r_iss_done)) && w_room;
    assign w_iss_end  = ({1'b0, r_rptr} == (r_fcnt[r_rd_bank] - CW'(1)));
    assign w_iss_last = w_iss_end && (w_pass_cur == 8'd0);
    assign w_slot     = r_head ^ r_count[0];

`ifdef SCRATCH_PAD_REPLAY_EN
    logic [7:0] r_pass_left;

    // Passes remaining are latched from rd_repeat on the first issue of a bank.
    assign w_pass_cur = (w_rd_state == BankFull) ? rd_repeat : r_pass_left;

    // Count down one pass each time the address wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pass_left <= 8'd0;
        end else if (w_issue) begin
            r_pass_left <= (w_iss_end && !w_iss_last) ? (w_pass_cur - 8'd1) : w_pass_cur;
        end
    end
`else
    assign w_pass_cur = 8'd0;
`endif

    // Per-bank next state; writer and reader never touch the same bank in one cycle.
    always_comb begin
        w_state_d = r_state;
        w_fcnt_d  = r_fcnt;
        if (w_wr_fire) begin
            if (w_commit) begin
                w_state_d[r_wr_bank] = BankFull;
                w_fcnt_d[r_wr_bank]  = {1'b0, r_wptr} + CW'(1);
            end else begin
                w_state_d[r_wr_bank] = BankFilling;
            end
        end
        if (w_issue && (w_rd_state == BankFull)) begin
            w_state_d[r_rd_bank] = BankDraining;
        end
        if (w_release) begin
            w_state_d[r_rd_bank] = BankEmpty;
        end
    end

    // Bank state, pointers and the read-issue sequencer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state[0] <= BankEmpty;
            r_state[1] <= BankEmpty;
            r_fcnt[0]  <= '0;
            r_fcnt[1]  <= '0;
            r_wr_bank  <= 1'b0;
            r_rd_bank  <= 1'b0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_iss_done <= 1'b0;
            r_inflight <= 1'b0;
            r_q_last   <= 1'b0;
        end else begin
            r_state    <= w_state_d;
            r_fcnt     <= w_fcnt_d;
            r_inflight <= w_issue;
            r_q_last   <= w_iss_last;
            if (w_wr_fire) begin
                r_wptr <= w_commit ? '0 : (r_wptr + AW'(1));
                if (w_commit) begin
                    r_wr_bank <= ~r_wr_bank;
                end
            end
            if (w_release) begin
                r_rd_bank  <= ~r_rd_bank;
                r_rptr     <= '0;
                r_iss_done <= 1'b0;
            end else if (w_issue) begin
                if (w_iss_end) begin
                    if (w_iss_last) begin
                        r_iss_done <= 1'b1;
                    end else begin
                        r_rptr <= '0;
                    end
                end else begin
                    r_rptr <= r_rptr + AW'(1);
                end
            end
        end
    end

    // Two-entry output skid fed by the RAM read register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_skid_data[0] <= '0;
            r_skid_data[1] <= '0;
            r_skid_last[0] <= 1'b0;
            r_skid_last[1] <= 1'b0;
            r_head         <= 1'b0;
            r_count        <= 2'd0;
        end else begin
            if (r_inflight) begin
                r_skid_data[w_slot] <= w_q[r_rd_bank];
                r_skid_last[w_slot] <= r_q_last;
            end
            if (w_pop) begin
                r_head <= ~r_head;
            end
            r_count <= r_count + {1'b0, r_inflight} - {1'b0, w_pop};
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        sp_bank #(
            .WIDTH (LW),
            .DEPTH (DEPTH)
        ) u_bank (
            .clk     (clk),
            .i_we    (w_wr_fire && (r_wr_bank == 1'(b))),
            .i_waddr (r_wptr),
            .i_wdata (wr_data),
            .i_re    (w_issue && (r_rd_bank == 1'(b))),
            .i_raddr (r_rptr),
            .o_rdata (w_q[b])
        );
    end

    assign w_head_line = r_skid_data[r_head];
    assign wr_ready    = w_wr_ready;
    assign rd_valid    = w_rd_valid;
    assign rd_last     = w_rd_valid && r_skid_last[r_head];
    assign rd_data_a   = w_head_line[A_LSB +: A_LANES*LANE_W];
    assign rd_data_b   = w_head_line[B_LSB +: B_LANES*LANE_W];
    assign bank_full   = {(r_state[1] == BankFull) || (r_state[1] == BankDraining),
                          (r_state[0] == BankFull) || (r_state[0] == BankDraining)};

endmodule
